// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - UART command frame parser issuing register writes/reads with a 1-byte reply
module uart_cmd_ctrl #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned TIMEOUT   = 100000,
    parameter logic [7:0]  ACK_BYTE  = 8'h06,
    parameter logic [7:0]  NAK_BYTE  = 8'h15
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_valid,
    output logic [7:0] o_tx_data,
    output logic       o_tx_valid,
    input  logic       i_tx_ready,
    output logic [7:0] o_reg_addr,
    output logic [7:0] o_reg_wdata,
    output logic       o_reg_wr,
    input  logic [7:0] i_reg_rdata,
    output logic [7:0] o_err_count
);

    localparam int          TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [7:0]  CMD_WR   = 8'h57;
    localparam logic [7:0]  CMD_RD   = 8'h52;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DATA, S_CSUM, S_EXEC, S_RESP
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [7:0]    data_q, data_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          wr_q, wr_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic [7:0]    err_q, err_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_event;
    logic [7:0]    sum;

    assign sum = cmd_q + addr_q + data_q;

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        data_d     = data_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_d       = 1'b0;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        tmo_d      = '0;
        err_event  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_rx_valid && i_rx_data == SYNC_BYTE) state_d = S_CMD;
            end
            S_CMD, S_ADDR, S_DATA, S_CSUM: begin
                if (i_rx_valid) begin
                    case (state_q)
                        S_CMD:   begin cmd_d  = i_rx_data; state_d = S_ADDR; end
                        S_ADDR:  begin addr_d = i_rx_data; state_d = S_DATA; end
                        S_DATA:  begin data_d = i_rx_data; state_d = S_CSUM; end
                        default: begin
                            // Decide the reply on the CSUM strobe so strobe and reply appear in EXEC.
                            state_d    = S_EXEC;
                            tx_valid_d = 1'b1;
                            if (sum == i_rx_data && cmd_q == CMD_WR) begin
                                wr_d      = 1'b1;
                                wdata_d   = data_q;
                                tx_data_d = ACK_BYTE;
                            end else if (sum == i_rx_data && cmd_q == CMD_RD) begin
                                tx_data_d = i_reg_rdata;
                            end else begin
                                tx_data_d = NAK_BYTE;
                                err_event = 1'b1;
                            end
                        end
                    endcase
                end else if (tmo_q == TMO_LAST) begin
                    state_d   = S_IDLE;
                    err_event = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_EXEC, S_RESP: begin
                if (i_rx_valid) err_event = 1'b1;
                if (tx_valid_q && i_tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase

        err_d = (err_event && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            cmd_q      <= '0;
            data_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_q       <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            err_q      <= '0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wr_q       <= wr_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
        end
    end

    assign o_tx_data   = tx_data_q;
    assign o_tx_valid  = tx_valid_q;
    assign o_reg_addr  = addr_q;
    assign o_reg_wdata = wdata_q;
    assign o_reg_wr    = wr_q;
    assign o_err_count = err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - frame vectors and corner-case sequences for uart_cmd_ctrl
module tb_uart_cmd_ctrl;

    localparam int TMO = 20;

    logic       clk = 1'b0;
    logic       rst_n, rx_valid, tx_valid, tx_ready, reg_wr;
    logic [7:0] rx_data, tx_data, reg_addr, reg_wdata, reg_rdata, err_count;

    always #5 clk = ~clk;

    // Register file model: every address reads back as addr ^ C4 (addr 07 -> C3).
    assign reg_rdata = reg_addr ^ 8'hC4;

    uart_cmd_ctrl #(.TIMEOUT(TMO)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
        .o_reg_addr(reg_addr), .o_reg_wdata(reg_wdata), .o_reg_wr(reg_wr),
        .i_reg_rdata(reg_rdata), .o_err_count(err_count)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int exp_err = 0;
    logic [7:0]  rsp_q[$];
    logic [15:0] wr_q[$];

    typedef struct {
        logic [7:0] cmd, addr, data, csum, reply;
        bit         wr, nak;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_valid && tx_ready) begin
                if (rsp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_reply: got %0h expected none", tx_data);
                end else chk("reply", tx_data, rsp_q.pop_front());
            end
            if (reg_wr) begin
                if (wr_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_write: got %0h expected none", {reg_addr, reg_wdata});
                end else chk("write_addr_data", {reg_addr, reg_wdata}, wr_q.pop_front());
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(posedge clk); #1;
        rx_data = b; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (rsp_q.size() == 0 && wr_q.size() == 0 && !tx_valid) break;
        end
        if (k == 200) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_timeout: got pending %0d expected 0", name, rsp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic run_vec(input vec_t v, input int gap, input string name);
        rsp_q.push_back(v.reply);
        if (v.wr) wr_q.push_back({v.addr, v.data});
        if (v.nak) exp_err++;
        send_byte(8'hA5, gap);
        send_byte(v.cmd, gap);
        send_byte(v.addr, gap);
        send_byte(v.data, gap);
        send_byte(v.csum, 0);
        chk({name, "_tx_valid_latency"}, tx_valid, 1'b1);
        chk({name, "_wr_latency"}, reg_wr, v.wr);
        wait_done(name);
        chk({name, "_err"}, err_count, exp_err);
    endtask

    initial begin
        logic stable;
        vecs[0] = '{cmd:8'h57, addr:8'h03, data:8'h42, csum:8'h9C, reply:8'h06, wr:1'b1, nak:1'b0};
        vecs[1] = '{cmd:8'h52, addr:8'h07, data:8'h00, csum:8'h59, reply:8'hC3, wr:1'b0, nak:1'b0};
        vecs[2] = '{cmd:8'h57, addr:8'h03, data:8'h42, csum:8'h00, reply:8'h15, wr:1'b0, nak:1'b1};
        vecs[3] = '{cmd:8'h41, addr:8'h01, data:8'h02, csum:8'h44, reply:8'h15, wr:1'b0, nak:1'b1};
        vecs[4] = '{cmd:8'h57, addr:8'h10, data:8'hFF, csum:8'h66, reply:8'h06, wr:1'b1, nak:1'b0};
        vecs[5] = '{cmd:8'h52, addr:8'h00, data:8'h5A, csum:8'hAC, reply:8'hC4, wr:1'b0, nak:1'b0};
        vecs[6] = '{cmd:8'h52, addr:8'h07, data:8'h00, csum:8'h58, reply:8'h15, wr:1'b0, nak:1'b1};

        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_reg_addr", reg_addr, 8'h00);
        chk("rst_reg_wr", reg_wr, 1'b0);
        chk("rst_err", err_count, 8'h00);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], 0, $sformatf("vec%0d", i));

        // Widest inter-byte gap that must still be accepted.
        run_vec(vecs[4], TMO - 2, "max_gap");

        // Abandoned frame: no reply, one error, then a clean frame.
        send_byte(8'hA5, 0);
        send_byte(8'h57, TMO + 5);
        exp_err++;
        chk("timeout_err", err_count, exp_err);
        chk("timeout_no_reply", tx_valid, 1'b0);
        run_vec(vecs[0], 0, "after_timeout");

        // Backpressure: reply held stable; a byte arriving during RESP is dropped.
        tx_ready = 1'b0;
        rsp_q.push_back(8'h06);
        wr_q.push_back(16'h0342);
        send_byte(8'hA5, 0); send_byte(8'h57, 0); send_byte(8'h03, 0);
        send_byte(8'h42, 0); send_byte(8'h9C, 0);
        stable = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (!(tx_valid === 1'b1 && tx_data === 8'h06)) stable = 1'b0;
        end
        chk("bp_stable", stable, 1'b1);
        send_byte(8'h33, 0);
        exp_err++;
        chk("bp_drop_err", err_count, exp_err);
        chk("bp_still_valid", tx_valid, 1'b1);
        tx_ready = 1'b1;
        wait_done("bp");
        chk("bp_err", err_count, exp_err);

        // Reset in DATA state, then junk before SYNC.
        send_byte(8'hA5, 0); send_byte(8'h57, 0); send_byte(8'h03, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_err = 0;
        chk("midrst_reg_addr", reg_addr, 8'h00);
        chk("midrst_err", err_count, 8'h00);
        chk("midrst_tx_valid", tx_valid, 1'b0);
        rst_n = 1'b1;
        send_byte(8'h00, 0); send_byte(8'h57, 0); send_byte(8'h9C, 0);
        chk("junk_err", err_count, 8'h00);
        run_vec(vecs[0], 0, "after_reset");

        chk("rsp_queue_empty", rsp_q.size(), 0);
        chk("wr_queue_empty", wr_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
